// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: op-codes, FSM
// states, default widths and the round-robin pick rule.
package alu_arbiter_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_e;

    // Index of the winning requester. A lone requester wins outright;
    // when both ask, the priority pointer decides.
    function automatic logic pick_winner(input logic [1:0] req, input logic ptr);
        logic w;
        case (req)
            2'b01:   w = 1'b0;
            2'b10:   w = 1'b1;
            default: w = ptr;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/operand/result bundle between the requesters and the arbiter.
interface alu_arbiter_if
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
);

    logic [1:0]       req;
    logic [1:0]       op0;
    logic [1:0]       op1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             busy;
    logic [CNT_W-1:0] txn_cnt;

    modport master (
        output req, op0, op1, a0, b0, a1, b1,
        input  gnt, done, result, carry, busy, txn_cnt
    );

    modport slave (
        input  req, op0, op1, a0, b0, a1, b1,
        output gnt, done, result, carry, busy, txn_cnt
    );

endinterface

// File: rtl/alu_arbiter_alu4.sv
// Combinational ALU: add/sub/and/xor with carry (add) or borrow (sub).
module alu4
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // Extended-width add and subtract; the top bit of the difference is
    // the borrow, i.e. set exactly when a < b.
    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} - {1'b0, b};
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            OP_SUB: begin
                result = diff[WIDTH-1:0];
                carry  = diff[WIDTH];
            end
            OP_AND:  result = a & b;
            OP_XOR:  result = a ^ b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter in front of a single shared ALU. One transaction
// takes three cycles: capture, execute, report.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting; any req bit captures the winner's op/operands
//   EXEC  | ALU evaluates captured operands, result/carry registered
//   DONE  | done pulse to the granted requester, gnt held, count bumps
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);

    state_e           state_q;
    state_e           state_d;
    logic             ptr_q;
    logic [1:0]       gnt_q;
    op_e              op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;

    logic             win;
    op_e              cap_op;
    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;

    alu4 #(.WIDTH(WIDTH)) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result),
        .carry  (alu_carry)
    );

    // Select the winner and its operands for capture in IDLE.
    always_comb begin
        win    = pick_winner(bus.req, ptr_q);
        cap_op = win ? op_e'(bus.op1) : op_e'(bus.op0);
        cap_a  = win ? bus.a1 : bus.a0;
        cap_b  = win ? bus.b1 : bus.b0;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|bus.req) state_d = EXEC;
            EXEC:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture, execute and count registers, sequenced by the current state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q    <= 1'b0;
            gnt_q    <= 2'b00;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|bus.req) begin
                        gnt_q <= win ? 2'b10 : 2'b01;
                        ptr_q <= ~win;
                        op_q  <= cap_op;
                        a_q   <= cap_a;
                        b_q   <= cap_b;
                    end
                end
                EXEC: begin
                    result_q <= alu_result;
                    carry_q  <= alu_carry;
                end
                DONE: begin
                    gnt_q <= 2'b00;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs: done mirrors the grant only while reporting.
    always_comb begin
        bus.busy    = (state_q != IDLE);
        bus.done    = 2'b00;
        if (state_q == DONE) bus.done = gnt_q;
        bus.gnt     = gnt_q;
        bus.result  = result_q;
        bus.carry   = carry_q;
        bus.txn_cnt = cnt_q;
    end

endmodule
